maple_frame_rx: RTL and testbench
=================================

MAPLE_FRAME_RX -- requirements
Module: maple_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the input synchronizer depth (at least 2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, the idle-edge cycles before a frame is aborted.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port sdcka_in, input, 1, the raw Maple SDCKA line.
REQ-006 SHALL have port sdckb_in, input, 1, the raw Maple SDCKB line.
REQ-007 SHALL have port out_data, output, 8, the received byte.
REQ-008 SHALL have port out_valid, output, 1, asserted while out_data holds an unconsumed byte.
REQ-009 SHALL have port out_ready, input, 1, the downstream FIFO accept signal.
REQ-010 SHALL have port frame_start, output, 1, a one-cycle pulse when the start pattern completes.
REQ-011 SHALL have port frame_end, output, 1, a one-cycle pulse when the end pattern completes.
REQ-012 SHALL have port byte_count, output, 9, the number of bytes in the current or last frame.
REQ-013 SHALL have port err, output, 2, a sticky error code: 0 none, 1 overflow, 2 timeout, 3 framing.
REQ-014 SHALL have port err_clr, input, 1, which clears err to 0.

Function
REQ-015 SHALL pass both lines through SYNC_STAGES flops, then one edge-detect flop; decoder latency is SYNC_STAGES+1 cycles.
REQ-016 SHALL implement the states IDLE, START, DATA_A, DATA_B, END and ABORT.
REQ-017 IDLE: when A falls while B is high, SHALL go to START and clear the B-pulse counter.
REQ-018 START: SHALL count B falls while A is low; on A rising with count == 4, pulse frame_start, zero byte_count and the bit counter, and go to DATA_A; on A rising with any other count, go to ABORT with err=3.
REQ-019 DATA_A: on A falling, SHALL shift in B (MSB first) and go to DATA_B.
REQ-020 DATA_A: if B falls while A is high and the bit counter is 0, SHALL go to END.
REQ-021 DATA_A: if B falls while A is high and the bit counter is not 0, SHALL set err=3 and go to ABORT.
REQ-022 DATA_B: on B falling, SHALL shift in A and go to DATA_A.
REQ-023 On the 8th bit, the bit counter SHALL wrap to 0, the byte SHALL be loaded into out_data with out_valid=1 on the next cycle, and byte_count SHALL increment, saturating at 511.
REQ-024 END: SHALL count A rises while B is low; on B rising with count == 2, pulse frame_end and go to IDLE; with any other count, set err=3 and go to ABORT.
REQ-025 ABORT: SHALL wait until both lines are high for 4 consecutive cycles, then go to IDLE.
REQ-026 Handshake: a byte transfers on a cycle with out_valid && out_ready; out_valid SHALL drop on the next cycle unless a new byte is loaded that same cycle.
REQ-027 out_data SHALL be stable while out_valid && !out_ready.
REQ-028 When a byte completes while out_valid is high and out_ready is low, the new byte SHALL be dropped, err SHALL be set to 1, and decoding SHALL continue.
REQ-029 When a byte completes while out_valid && out_ready in the same cycle, the new byte SHALL be loaded with no overflow.
REQ-030 A timeout counter SHALL reset on every synchronized edge; in any state except IDLE and ABORT, reaching TIMEOUT_CYC SHALL set err=2 and go to ABORT.
REQ-031 err SHALL record only the first error; when err_clr and a new error occur in the same cycle, the new error SHALL win.
REQ-032 When A and B fall in the same cycle (both edges detected together), the block SHALL set err=3 and go to ABORT, in any state except IDLE and ABORT.
REQ-033 frame_end SHALL NOT assert for an aborted frame; bytes already delivered are not retracted.

Reset
REQ-034 While reset is low, the block SHALL be in IDLE with out_valid=0, out_data=0, frame_start=0, frame_end=0, byte_count=0 and err=0.
REQ-035 While reset is low, the synchronizer flops SHALL be 1 and all counters SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL discard the partial byte; after release, decoding SHALL resume only from a fresh start pattern.

Structure
REQ-037 Package maple_pkg SHALL hold the state enum, the error-code constants (ERR_NONE, ERR_OVF, ERR_TMO, ERR_FRM), START_PULSES=4 and END_PULSES=2.
REQ-038 Sub-module maple_line_sync SHALL hold the synchronizer and rise/fall detection for one line, instantiated twice.

Verification
REQ-039 Send a start pattern, bytes 0xA5 and 0x3C, then an end pattern, with out_ready=1 -> frame_start once; out_data 0xA5 then 0x3C, one valid cycle each; frame_end once; byte_count=2; err=0.
REQ-040 Send the same frame with out_ready held low -> out_data=0xA5 is held; err=1 when 0x3C completes; after raising out_ready, 0xA5 is taken and no 0x3C is ever presented.
REQ-041 Send a start pattern with only 3 B pulses -> no frame_start; err=3; returns to IDLE after the lines are idle for 4 cycles.
REQ-042 Stop the line toggling mid-byte for TIMEOUT_CYC cycles -> err=2 at cycle TIMEOUT_CYC; no frame_end.
REQ-043 Assert reset after 3 bits of a byte, release it, then send a full 1-byte frame of 0x81 -> only 0x81 is delivered; byte_count=1.
REQ-044 Pulse err_clr in the same cycle as an overflow -> err=1.

Source files
------------

// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - shared types and constants for the Maple frame receiver
package maple_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA_A,
    DATA_B,
    END,
    ABORT
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_FRM  = 2'd3;

  localparam int START_PULSES   = 4;
  localparam int END_PULSES     = 2;
  localparam int ABORT_IDLE_CYC = 4;

  // Sticky first-error capture; a new error beats a simultaneous clear.
  function automatic logic [1:0] err_update(input logic [1:0] cur, input logic clr,
                                            input logic [1:0] code);
    if (code != ERR_NONE && (cur == ERR_NONE || clr)) return code;
    if (clr) return ERR_NONE;
    return cur;
  endfunction

endpackage

// File: rtl/maple_frame_rx_if.sv
// rtl/maple_frame_rx_if.sv - received-byte stream between decoder and downstream FIFO
interface maple_frame_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master(output out_data, output out_valid, input out_ready);
  modport slave(input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/maple_frame_rx_line_sync.sv
// rtl/maple_frame_rx_line_sync.sv - per-line synchronizer and edge detector (maple_line_sync)
// Flops reset to 1 so an idle-high bus produces no edge after reset release.
module maple_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/maple_frame_rx.sv
// rtl/maple_frame_rx.sv - Maple bus SDCKA/SDCKB frame decoder with byte stream output
// Bits alternate: A falling samples B, then B falling samples A; MSB first.
module maple_frame_rx
  import maple_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdcka_in,
  input  logic             sdckb_in,
  maple_frame_rx_if.master out_if,
  output logic             frame_start,
  output logic             frame_end,
  output logic [8:0]       byte_count,
  output logic [1:0]       err,
  input  logic             err_clr
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic w_a_lvl, w_a_rise, w_a_fall;
  logic w_b_lvl, w_b_rise, w_b_fall;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_start, r_frame_end;
  logic [8:0]       r_byte_count;
  logic [1:0]       r_err;

  logic       w_any_edge, w_tmo_hit, w_active;
  logic       w_do_shift, w_shift_in, w_byte_done;
  logic       w_fs, w_fe, w_load, w_ovf;
  logic [1:0] w_err_new, w_err_code;

  maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(clk), .reset(reset), .i_line(sdcka_in),
    .o_level(w_a_lvl), .o_rise(w_a_rise), .o_fall(w_a_fall)
  );

  maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(clk), .reset(reset), .i_line(sdckb_in),
    .o_level(w_b_lvl), .o_rise(w_b_rise), .o_fall(w_b_fall)
  );

  assign w_any_edge = w_a_rise | w_a_fall | w_b_rise | w_b_fall;
  assign w_tmo_hit  = !w_any_edge && (r_tmo == TMO_LAST);
  assign w_active   = (r_state != IDLE) && (r_state != ABORT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_do_shift  = 1'b0;
    w_shift_in  = 1'b0;
    w_byte_done = 1'b0;
    w_fs        = 1'b0;
    w_fe        = 1'b0;
    w_err_new   = ERR_NONE;

    if (w_active && w_a_fall && w_b_fall) begin
      w_state_nxt = ABORT;
      w_cnt_nxt   = 3'd0;
      w_err_new   = ERR_FRM;
    end else if (w_active && w_tmo_hit) begin
      w_state_nxt = ABORT;
      w_cnt_nxt   = 3'd0;
      w_err_new   = ERR_TMO;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_a_fall && w_b_lvl) begin
            w_state_nxt = START;
            w_cnt_nxt   = 3'd0;
          end
        end
        START: begin
          if (w_a_rise) begin
            if (r_cnt == 3'(START_PULSES)) begin
              w_state_nxt = DATA_A;
              w_bit_nxt   = 3'd0;
              w_fs        = 1'b1;
            end else begin
              w_state_nxt = ABORT;
              w_cnt_nxt   = 3'd0;
              w_err_new   = ERR_FRM;
            end
          end else if (w_b_fall && !w_a_lvl && r_cnt != 3'd7) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        DATA_A: begin
          if (w_a_fall) begin
            w_do_shift  = 1'b1;
            w_shift_in  = w_b_lvl;
            w_state_nxt = DATA_B;
          end else if (w_b_fall && w_a_lvl) begin
            w_cnt_nxt = 3'd0;
            if (r_bit == 3'd0) begin
              w_state_nxt = END;
            end else begin
              w_state_nxt = ABORT;
              w_err_new   = ERR_FRM;
            end
          end
        end
        DATA_B: begin
          if (w_b_fall) begin
            w_do_shift  = 1'b1;
            w_shift_in  = w_a_lvl;
            w_state_nxt = DATA_A;
          end
        end
        END: begin
          if (w_b_rise) begin
            w_cnt_nxt = 3'd0;
            if (r_cnt == 3'(END_PULSES)) begin
              w_state_nxt = IDLE;
              w_fe        = 1'b1;
            end else begin
              w_state_nxt = ABORT;
              w_err_new   = ERR_FRM;
            end
          end else if (w_a_rise && !w_b_lvl && r_cnt != 3'd7) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        ABORT: begin
          if (w_a_lvl && w_b_lvl) begin
            if (r_cnt == 3'(ABORT_IDLE_CYC - 1)) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = 3'd0;
            end else begin
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end else begin
            w_cnt_nxt = 3'd0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    if (w_do_shift) begin
      w_shift_nxt = {r_shift[6:0], w_shift_in};
      w_bit_nxt   = r_bit + 3'd1;
      w_byte_done = (r_bit == 3'd7);
    end
  end

  // A completed byte lands only when the holding register is free or being drained.
  assign w_load     = w_byte_done && (!r_valid || out_if.out_ready);
  assign w_ovf      = w_byte_done && r_valid && !out_if.out_ready;
  assign w_err_code = (w_err_new != ERR_NONE) ? w_err_new : (w_ovf ? ERR_OVF : ERR_NONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= 3'd0;
      r_bit         <= 3'd0;
      r_shift       <= 8'd0;
      r_tmo         <= '0;
      r_data        <= 8'd0;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_byte_count  <= 9'd0;
      r_err         <= ERR_NONE;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_bit         <= w_bit_nxt;
      r_shift       <= w_shift_nxt;
      r_frame_start <= w_fs;
      r_frame_end   <= w_fe;
      r_err         <= err_update(r_err, err_clr, w_err_code);

      if (w_any_edge)             r_tmo <= '0;
      else if (r_tmo != TMO_LAST) r_tmo <= r_tmo + 1'b1;

      if (w_load) begin
        r_data  <= w_shift_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && out_if.out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_fs)                                    r_byte_count <= 9'd0;
      else if (w_byte_done && r_byte_count != 9'd511) r_byte_count <= r_byte_count + 9'd1;
    end
  end

  assign out_if.out_data  = r_data;
  assign out_if.out_valid = r_valid;
  assign frame_start      = r_frame_start;
  assign frame_end        = r_frame_end;
  assign byte_count       = r_byte_count;
  assign err              = r_err;

endmodule

// File: tb/tb_maple_frame_rx.sv
// tb/tb_maple_frame_rx.sv - self-checking bench for maple_frame_rx
// Frames are built from line-level steps; expected bytes come from a queue model.
module tb_maple_frame_rx;

  localparam int TMO  = 200;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sda = 1'b1;
  logic       sdb = 1'b1;
  logic       err_clr = 1'b0;
  logic       frame_start, frame_end;
  logic [8:0] byte_count;
  logic [1:0] err;

  maple_frame_rx_if bus ();

  maple_frame_rx #(.SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .sdcka_in(sda), .sdckb_in(sdb), .out_if(bus),
    .frame_start(frame_start), .frame_end(frame_end), .byte_count(byte_count),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         fs_cnt = 0, fe_cnt = 0, valid_cycles = 0;
  int         fs0, fe0;
  logic [7:0] exp_q[$];
  logic [7:0] fq[$];
  bit         rand_ready = 1'b0;
  logic       ready_level = 1'b1;
  logic       hold_chk = 1'b0;
  logic [7:0] hold_d = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: with the sink stalled only the first byte survives and
  // every later byte of the frame is an overflow; otherwise all bytes arrive in order.
  task automatic model_frame(input bit stalled);
    if (stalled) exp_q.push_back(fq[0]);
    else foreach (fq[k]) exp_q.push_back(fq[k]);
  endtask

  function automatic logic [1:0] model_err(input bit stalled);
    return (stalled && fq.size() > 1) ? 2'd1 : 2'd0;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_chk = 1'b0;
      end else begin
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
        if (bus.out_valid) valid_cycles++;
        if (hold_chk) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", bus.out_data, hold_d);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", bus.out_data);
          end else begin
            check("out_data", bus.out_data, exp_q.pop_front());
          end
        end
        hold_chk = bus.out_valid && !bus.out_ready;
        hold_d   = bus.out_data;
      end
    end
  end

  task automatic step(input logic a, input logic b, input bit clr);
    @(posedge clk);
    #2;
    sda = a;
    sdb = b;
    err_clr = clr;
    repeat (HOLD - 1) @(posedge clk);
    #2 err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_start(input int pulses);
    step(1'b0, 1'b1, 1'b0);
    repeat (pulses) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] data, input int nbits, input bit clr_last);
    for (int i = 0; i < nbits; i++) begin
      logic d;
      d = data[7-i];
      if (i % 2 == 0) begin
        step(1'b1, d, 1'b0);
        step(1'b0, d, 1'b0);
      end else begin
        step(d, 1'b1, 1'b0);
        step(d, 1'b0, clr_last && (i == nbits - 1));
      end
    end
  endtask

  task automatic send_end();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input bit clr_last);
    send_start(4);
    foreach (fq[k]) send_bits(fq[k], 8, clr_last && (k == fq.size() - 1));
    send_end();
    idle(2);
  endtask

  task automatic clear_err();
    @(posedge clk);
    #2 err_clr = 1'b1;
    @(posedge clk);
    #2 err_clr = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_fs", frame_start, 0);
    check("rst_fe", frame_end, 0);
    check("rst_bc", byte_count, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(2);

    // Nominal two-byte frame, sink always ready.
    fq.delete(); fq.push_back(8'hA5); fq.push_back(8'h3C);
    model_frame(1'b0);
    fs0 = fs_cnt; fe0 = fe_cnt; valid_cycles = 0;
    send_frame(1'b0);
    drain();
    check("s1_fs", fs_cnt - fs0, 1);
    check("s1_fe", fe_cnt - fe0, 1);
    check("s1_bc", byte_count, 2);
    check("s1_err", err, model_err(1'b0));
    check("s1_valid_cyc", valid_cycles, 2);

    // Stalled sink: second byte overflows in the same cycle err_clr is pulsed.
    ready_level = 1'b0;
    repeat (2) @(posedge clk);
    model_frame(1'b1);
    fe0 = fe_cnt;
    send_frame(1'b1);
    @(negedge clk);
    check("s2_valid", bus.out_valid, 1);
    check("s2_data", bus.out_data, 8'hA5);
    check("s2_err", err, model_err(1'b1));
    check("s2_err_lit", err, 1);
    check("s2_fe", fe_cnt - fe0, 1);
    ready_level = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("s2_valid_off", bus.out_valid, 0);
    check("s2_left", exp_q.size(), 0);
    clear_err();
    @(negedge clk);
    check("s2_err_clr", err, 0);

    // Short start pattern aborts, then a good frame still decodes.
    fs0 = fs_cnt;
    send_start(3);
    idle(3);
    @(negedge clk);
    check("s3_err", err, 3);
    check("s3_fs", fs_cnt - fs0, 0);
    clear_err();
    fq.delete(); fq.push_back(8'hC3);
    model_frame(1'b0);
    send_frame(1'b0);
    drain();
    check("s3_fs_after", fs_cnt - fs0, 1);
    check("s3_bc", byte_count, 1);

    // Lines freeze mid-byte.
    fe0 = fe_cnt;
    send_start(4);
    send_bits(8'hB0, 3, 1'b0);
    repeat (TMO - HOLD - 10) @(posedge clk);
    @(negedge clk);
    check("s4_err_early", err, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("s4_err_tmo", err, 2);
    idle(3);
    check("s4_fe", fe_cnt - fe0, 0);
    clear_err();

    // Reset mid-byte, then a fresh one-byte frame.
    send_start(4);
    send_bits(8'hFF, 3, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    sda = 1'b1;
    sdb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s5_rst_bc", byte_count, 0);
    check("s5_rst_valid", bus.out_valid, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(2);
    fq.delete(); fq.push_back(8'h81);
    model_frame(1'b0);
    fs0 = fs_cnt; fe0 = fe_cnt;
    send_frame(1'b0);
    drain();
    check("s5_bc", byte_count, 1);
    check("s5_fs", fs_cnt - fs0, 1);
    check("s5_fe", fe_cnt - fe0, 1);
    check("s5_err", err, 0);

    // Simultaneous fall of both lines inside a frame.
    fe0 = fe_cnt;
    send_start(4);
    step(1'b0, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    check("s6_err", err, 3);
    check("s6_fe", fe_cnt - fe0, 0);
    clear_err();

    // Random frames against a randomly stalling sink.
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 4);
      fq.delete();
      for (int k = 0; k < n; k++) fq.push_back(8'($urandom));
      fq[0][7] = 1'b1;
      model_frame(1'b0);
      fs0 = fs_cnt; fe0 = fe_cnt;
      send_frame(1'b0);
      drain();
      check("rnd_bc", byte_count, n);
      check("rnd_err", err, 0);
      check("rnd_fs", fs_cnt - fs0, 1);
      check("rnd_fe", fe_cnt - fe0, 1);
    end
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
